// File: rtl/fpsu_ret_collect.sv
// fpsu_ret_collect -- completion collector between the FP SIMD unit outputs
// and the ROB completion bus.
//
// Captures up to three 14-bit completion words per cycle (ports u1, u3, u5),
// queues them in port order in a circular buffer, and presents the two oldest
// entries to retire logic, which drains them under a ready handshake.
// Accepted words also OR their IEEE flags into a sticky register. A
// registered issue_hold warns the issue stage before the queue can overflow.
//
// Optional feature: define FPSU_RET_BYPASS_EN to forward incoming words
// combinationally into empty output slots (latency 0). Without the macro
// there is no input-to-output combinational path.
//
// Ports:
//   clk                       clock, all state on posedge
//   rst                       asynchronous active-low reset
//   u1/u3/u5_ret[13:0]        completion words: [4:0] NV,DZ,OF,UF,NX; [13:5] tag
//   u1/u3/u5_ret_en           completion strobes
//   out0_data/out1_data       oldest / second-oldest presented words
//   out_valid[1:0]            slot valids, [1] implies [0]
//   out_ready                 retire accepts every valid slot this cycle
//   issue_hold                registered back-pressure to issue
//   flags[4:0]                sticky OR of accepted exception fields
//   flags_clr                 one-cycle clear of flags
//   ovf_err                   sticky, a completion was dropped
module fpsu_ret_collect #(
    parameter int DEPTH       = 16,
    parameter int HOLD_MARGIN = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] u1_ret,
    input  logic [13:0] u3_ret,
    input  logic [13:0] u5_ret,
    input  logic        u1_ret_en,
    input  logic        u3_ret_en,
    input  logic        u5_ret_en,
    output logic [13:0] out0_data,
    output logic [13:0] out1_data,
    output logic [1:0]  out_valid,
    input  logic        out_ready,
    output logic        issue_hold,
    output logic [4:0]  flags,
    input  logic        flags_clr,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [13:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, space_s;
    logic [4:0]    flags_q, flags_d, acc_flags_s;
    logic          ovf_q, ovf_d, hold_q, hold_d;

    logic [13:0]   in_word_s [3];
    logic [2:0]    in_en_s, acc_s, wen_s;
    logic [1:0]    acc_idx_s [3];
    logic [AW-1:0] waddr_s [3];
    logic [1:0]    q_valid_s, n_popq_s, n_acc_s, n_byp_s;

    assign in_word_s[0] = u1_ret;
    assign in_word_s[1] = u3_ret;
    assign in_word_s[2] = u5_ret;
    assign in_en_s      = {u5_ret_en, u3_ret_en, u1_ret_en};

    // Queue-side pops and admission of incoming words in u1, u3, u5 order.
    always_comb begin
        q_valid_s   = {count_q >= CW'(2), count_q >= CW'(1)};
        n_popq_s    = out_ready ? ({1'b0, q_valid_s[1]} + {1'b0, q_valid_s[0]}) : 2'd0;
        // Space is judged after this cycle's pops from the queue.
        space_s     = CW'(DEPTH) - count_q + CW'(n_popq_s);
        n_acc_s     = 2'd0;
        acc_flags_s = 5'd0;
        ovf_d       = ovf_q;
        for (int i = 0; i < 3; i++) begin
            acc_s[i]     = 1'b0;
            acc_idx_s[i] = n_acc_s;
            if (in_en_s[i]) begin
                if (CW'(n_acc_s) < space_s) begin
                    acc_s[i]    = 1'b1;
                    n_acc_s     = n_acc_s + 2'd1;
                    acc_flags_s = acc_flags_s | in_word_s[i][4:0];
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                acc_s[i] = 1'b0;
            end
        end
    end

`ifdef FPSU_RET_BYPASS_EN
    logic [13:0] fwd0_s, fwd1_s;

    // Output slots: queued entries first, accepted incoming words fill the rest.
    always_comb begin
        fwd0_s = mem_q[rd_ptr_q];
        fwd1_s = mem_q[rd_ptr_q + AW'(1)];
        for (int i = 0; i < 3; i++) begin
            if (acc_s[i] && acc_idx_s[i] == 2'd0) begin
                fwd0_s = in_word_s[i];
            end else if (acc_s[i] && acc_idx_s[i] == 2'd1) begin
                fwd1_s = in_word_s[i];
            end else begin
                fwd0_s = fwd0_s;
            end
        end
        out0_data = mem_q[rd_ptr_q];
        out1_data = mem_q[rd_ptr_q + AW'(1)];
        out_valid = q_valid_s;
        n_byp_s   = 2'd0;
        if (count_q >= CW'(2)) begin
            n_byp_s = 2'd0;
        end else if (count_q == CW'(1)) begin
            out1_data = fwd0_s;
            out_valid = {n_acc_s != 2'd0, 1'b1};
            n_byp_s   = (out_ready && n_acc_s != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            out0_data = fwd0_s;
            out1_data = fwd1_s;
            out_valid = {n_acc_s >= 2'd2, n_acc_s != 2'd0};
            if (out_ready) begin
                n_byp_s = (n_acc_s >= 2'd2) ? 2'd2 : n_acc_s;
            end else begin
                n_byp_s = 2'd0;
            end
        end
    end
`else
    // Output slots come straight from queue storage.
    always_comb begin
        out0_data = mem_q[rd_ptr_q];
        out1_data = mem_q[rd_ptr_q + AW'(1)];
        out_valid = q_valid_s;
        n_byp_s   = 2'd0;
    end
`endif

    // Write addresses and next-state; words forwarded and popped are not stored.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wen_s[i]   = acc_s[i] && (acc_idx_s[i] >= n_byp_s);
            waddr_s[i] = wr_ptr_q + AW'(acc_idx_s[i] - n_byp_s);
        end
        wr_ptr_d = wr_ptr_q + AW'(n_acc_s - n_byp_s);
        rd_ptr_d = rd_ptr_q + AW'(n_popq_s);
        count_d  = count_q + CW'(n_acc_s) - CW'(n_byp_s) - CW'(n_popq_s);
        hold_d   = (CW'(DEPTH) - count_d) < CW'(HOLD_MARGIN);
        // Current-cycle flags survive a simultaneous clear.
        flags_d  = (flags_clr ? 5'd0 : flags_q) | acc_flags_s;
    end

    // Entry storage, zeroed on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= 14'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wen_s[i]) begin
                    mem_q[waddr_s[i]] <= in_word_s[i];
                end
            end
        end
    end

    // Pointers, occupancy and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= 5'd0;
            ovf_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            ovf_q    <= ovf_d;
            hold_q   <= hold_d;
        end
    end

    assign issue_hold = hold_q;
    assign flags      = flags_q;
    assign ovf_err    = ovf_q;
endmodule

// File: tb/tb_fpsu_ret_collect.sv
module tb_fpsu_ret_collect;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] u1_ret, u3_ret, u5_ret;
    logic        u1_ret_en, u3_ret_en, u5_ret_en;
    logic [13:0] out0_data, out1_data;
    logic [1:0]  out_valid;
    logic        out_ready, issue_hold, flags_clr, ovf_err;
    logic [4:0]  flags;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpsu_ret_collect #(.DEPTH(16), .HOLD_MARGIN(6)) dut (
        .clk(clk), .rst(rst),
        .u1_ret(u1_ret), .u3_ret(u3_ret), .u5_ret(u5_ret),
        .u1_ret_en(u1_ret_en), .u3_ret_en(u3_ret_en), .u5_ret_en(u5_ret_en),
        .out0_data(out0_data), .out1_data(out1_data), .out_valid(out_valid),
        .out_ready(out_ready), .issue_hold(issue_hold), .flags(flags),
        .flags_clr(flags_clr), .ovf_err(ovf_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] en, input logic [13:0] a, input logic [13:0] b,
                         input logic [13:0] c);
        {u5_ret_en, u3_ret_en, u1_ret_en} = en;
        u1_ret = a;
        u3_ret = b;
        u5_ret = c;
    endtask

    function automatic logic [13:0] wd(input int n);
        return {9'(n), 5'd0};
    endfunction

    logic [13:0] expq[$];
    int          sz;

    initial begin
        rst = 1'b0;
        out_ready = 1'b0;
        flags_clr = 1'b0;
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        tick;
        // Reset / idle state
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_out0", 16'(out0_data), 16'h0);
        chk("rst_out1", 16'(out1_data), 16'h0);
        chk("rst_hold", 16'(issue_hold), 16'h0);
        chk("rst_flags", 16'(flags), 16'h0);
        chk("rst_ovf", 16'(ovf_err), 16'h0);

        // Three ports in one cycle, latency 1
        drive(3'b111, 14'h0101, 14'h0202, 14'h0304);
        tick;
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        chk("tri_out0", 16'(out0_data), 16'h0101);
        chk("tri_out1", 16'(out1_data), 16'h0202);
        chk("tri_valid", 16'(out_valid), 16'h3);
        chk("tri_flags", 16'(flags), 16'h07);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("pop_out0", 16'(out0_data), 16'h0304);
        chk("pop_valid", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("drain_valid", 16'(out_valid), 16'h0);

        // Absent port skipped, no hole
        drive(3'b110, 14'h3FFF, 14'h0A00, 14'h0B00);
        tick;
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        chk("gap_out0", 16'(out0_data), 16'h0A00);
        chk("gap_out1", 16'(out1_data), 16'h0B00);
        chk("gap_valid", 16'(out_valid), 16'h3);
        chk("gap_flags", 16'(flags), 16'h07);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Flags: accumulate survives clear, then clear alone
        flags_clr = 1'b1;
        drive(3'b001, 14'h0011, 14'd0, 14'd0);
        tick;
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        chk("flag_clr_acc", 16'(flags), 16'h11);
        out_ready = 1'b1;
        tick;
        flags_clr = 1'b0;
        out_ready = 1'b0;
        chk("flag_clr", 16'(flags), 16'h0);
        chk("flag_q_empty", 16'(out_valid), 16'h0);

        // Fill to overflow: 6 cycles x 3 words, 16 accepted
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, wd(c * 3 + 1), wd(c * 3 + 2), wd(c * 3 + 3));
            tick;
            if (c == 2) chk("hold_at9", 16'(issue_hold), 16'h0);
            if (c == 3) chk("hold_at12", 16'(issue_hold), 16'h1);
            if (c == 4) chk("ovf_at15", 16'(ovf_err), 16'h0);
        end
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        chk("ovf_set", 16'(ovf_err), 16'h1);
        chk("full_valid", 16'(out_valid), 16'h3);
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("full_out0", 16'(out0_data), 16'(wd(2 * j + 1)));
            chk("full_out1", 16'(out1_data), 16'(wd(2 * j + 2)));
            tick;
            chk("full_hold", 16'(issue_hold), 16'((16 - 2 * (j + 1)) > 10));
        end
        out_ready = 1'b0;
        chk("full_empty", 16'(out_valid), 16'h0);
        chk("ovf_sticky", 16'(ovf_err), 16'h1);

        // Reset clears ovf before the wrap test
        rst = 1'b0;
        #1;
        chk("rst2_ovf", 16'(ovf_err), 16'h0);
        rst = 1'b1;
        tick;

        // Continuous 3-in / 2-out: pointers wrap, count climbs to 16,
        // then the 15th cycle drops its u5 word
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            sz = expq.size();
            chk("wrap_valid", 16'(out_valid), 16'({sz >= 2, sz >= 1}));
            if (sz >= 1) chk("wrap_out0", 16'(out0_data), 16'(expq[0]));
            if (sz >= 2) chk("wrap_out1", 16'(out1_data), 16'(expq[1]));
            for (int k = 0; k < 2; k++) begin
                if (expq.size() > 0 && k < sz) void'(expq.pop_front());
            end
            drive(3'b111, wd(100 + cyc * 3), wd(101 + cyc * 3), wd(102 + cyc * 3));
            expq.push_back(wd(100 + cyc * 3));
            expq.push_back(wd(101 + cyc * 3));
            if (cyc != 14) expq.push_back(wd(102 + cyc * 3));
            if (cyc == 14) chk("wrap_ovf_pre", 16'(ovf_err), 16'h0);
            tick;
        end
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        chk("wrap_ovf", 16'(ovf_err), 16'h1);
        for (int d = 0; d < 10; d++) begin
            sz = expq.size();
            if (sz > 0) begin
                chk("wdrain_valid", 16'(out_valid), 16'({sz >= 2, 1'b1}));
                chk("wdrain_out0", 16'(out0_data), 16'(expq[0]));
                if (sz >= 2) chk("wdrain_out1", 16'(out1_data), 16'(expq[1]));
                void'(expq.pop_front());
                if (sz >= 2) void'(expq.pop_front());
                tick;
            end
        end
        chk("wdrain_empty", 16'(out_valid), 16'h0);

        // Reset mid-operation empties the queue at once
        out_ready = 1'b0;
        drive(3'b111, wd(7), wd(8), wd(9));
        tick;
        drive(3'b000, 14'd0, 14'd0, 14'd0);
        chk("mid_valid", 16'(out_valid), 16'h3);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_out0", 16'(out0_data), 16'h0);
        rst = 1'b1;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
